// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory port arbiter for fetch (IF) and data (MEM) stages
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_kill,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_ready,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stall_F,
  output logic             stall_M
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            kill_pend;

  // Stalls follow the live request and the registered ready pulse
  assign stall_F = if_req & ~if_ready;
  assign stall_M = dm_req & ~dm_ready;

  // Arbitration FSM; ready is registered on the ack edge so it is high during RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      kill_pend  <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          // MEM holds the older instruction, so it wins unless fetch has starved
          if (if_req && (!dm_req || starve_cnt == STARVE_LIM)) begin
            state      <= IF_WAIT;
            mem_valid  <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end else if (dm_req) begin
            state     <= DM_WAIT;
            mem_valid <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        IF_WAIT: begin
          // A flush never aborts the bus transaction; it only hides the response
          if (mem_ack) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            if (kill_pend || if_kill) begin
              kill_pend <= 1'b1;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        DM_WAIT: begin
          if (mem_ack) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            dm_ready  <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          kill_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_valid, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_F, stall_M;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.WIDTH(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_F(stall_F), .stall_M(stall_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack after wait_n cycles, return at the RESP-cycle negedge
  task automatic serve(input int wait_n, input logic [31:0] data);
    repeat (wait_n) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0; if_kill = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_stall_F", stall_F, 0);
    chk("rst_stall_M", stall_M, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, minimum latency
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("f1_mem_valid", mem_valid, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_stall_F", stall_F, 1);
    chk("f1_if_ready_early", if_ready, 0);
    serve(0, 32'h00500093);
    chk("f1_if_ready", if_ready, 1);
    chk("f1_if_rdata", if_rdata, 32'h00500093);
    chk("f1_stall_F_resp", stall_F, 0);
    chk("f1_mem_valid_clr", mem_valid, 0);
    if_req = 0;
    @(negedge clk);
    chk("f1_if_ready_pulse", if_ready, 0);
    chk("f1_if_rdata_hold", if_rdata, 32'h00500093);

    // Simultaneous: store wins, fetch follows
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sim_mem_we", mem_we, 1);
    chk("sim_mem_addr", mem_addr, 32'h2000);
    chk("sim_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sim_stall_F", stall_F, 1);
    chk("sim_stall_M", stall_M, 1);
    serve(0, 32'h12345678);
    chk("sim_dm_ready", dm_ready, 1);
    chk("sim_dm_rdata_write", dm_rdata, 32'h0);
    chk("sim_if_ready", if_ready, 0);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("sim_no_arb_in_resp", mem_valid, 0);
    chk("sim_dm_ready_pulse", dm_ready, 0);
    @(negedge clk);
    chk("sim_if_grant_valid", mem_valid, 1);
    chk("sim_if_grant_addr", mem_addr, 32'h104);
    chk("sim_if_grant_we", mem_we, 0);
    serve(1, 32'hAAAA0001);
    chk("sim_if_ready", if_ready, 1);
    chk("sim_if_rdata", if_rdata, 32'hAAAA0001);
    if_req = 0;
    @(negedge clk);

    // Starvation: four loads, then fetch is forced through
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
    if_req = 1; if_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stv_dm_grant_addr", mem_addr, 32'h3000);
      serve(0, 32'h100 + i);
      chk("stv_dm_ready", dm_ready, 1);
      chk("stv_dm_rdata", dm_rdata, 32'h100 + i);
      @(negedge clk);
    end
    @(negedge clk);
    chk("stv_if_grant_addr", mem_addr, 32'h200);
    chk("stv_if_grant_we", mem_we, 0);
    chk("stv_stall_M", stall_M, 1);
    serve(0, 32'h5555AAAA);
    chk("stv_if_ready", if_ready, 1);
    chk("stv_if_rdata", if_rdata, 32'h5555AAAA);
    @(negedge clk);
    @(negedge clk);
    chk("stv_cnt_cleared_dm_wins", mem_addr, 32'h3000);
    serve(0, 32'h00000777);
    chk("stv_dm_ready2", dm_ready, 1);
    chk("stv_dm_rdata2", dm_rdata, 32'h00000777);
    dm_req = 0; if_req = 0;
    @(negedge clk);

    // Ack while idle is ignored
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 0; mem_rdata = 0;
    chk("idle_ack_dm_ready", dm_ready, 0);
    chk("idle_ack_if_ready", if_ready, 0);
    chk("idle_ack_dm_rdata", dm_rdata, 32'h00000777);

    // Kill during IF_WAIT, ack three cycles later
    if_req = 1; if_addr = 32'h300;
    @(negedge clk);
    chk("kill_mem_valid", mem_valid, 1);
    if_kill = 1; if_req = 0;
    @(negedge clk);
    if_kill = 0;
    chk("kill_txn_held", mem_valid, 1);
    chk("kill_txn_addr", mem_addr, 32'h300);
    serve(1, 32'hBAD0BAD0);
    chk("kill_if_ready", if_ready, 0);
    chk("kill_if_rdata", if_rdata, 32'h5555AAAA);
    chk("kill_mem_valid_clr", mem_valid, 0);
    @(negedge clk);
    chk("kill_if_ready_idle", if_ready, 0);
    if_req = 1; if_addr = 32'h400;
    @(negedge clk);
    chk("kill_next_addr", mem_addr, 32'h400);
    serve(0, 32'h00A00113);
    chk("kill_next_ready", if_ready, 1);
    chk("kill_next_rdata", if_rdata, 32'h00A00113);
    @(negedge clk);

    // Kill coinciding with the ack
    if_addr = 32'h500;
    @(negedge clk);
    if_kill = 1;
    serve(0, 32'hCAFEF00D);
    if_kill = 0;
    chk("killack_if_ready", if_ready, 0);
    chk("killack_if_rdata", if_rdata, 32'h00A00113);
    if_req = 0;
    @(negedge clk);

    // Asynchronous reset mid-transaction
    dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
    @(negedge clk);
    chk("rmid_mem_valid", mem_valid, 1);
    chk("rmid_mem_addr", mem_addr, 32'h5000);
    #2 rst = 1'b0;
    #1;
    chk("rmid_async_valid", mem_valid, 0);
    chk("rmid_async_addr", mem_addr, 0);
    chk("rmid_async_dm_rdata", dm_rdata, 0);
    chk("rmid_async_if_rdata", if_rdata, 0);
    chk("rmid_async_dm_ready", dm_ready, 0);
    dm_req = 0;
    #1;
    chk("rmid_stall_M", stall_M, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h6000;
    @(negedge clk);
    chk("rpost_mem_addr", mem_addr, 32'h6000);
    chk("rpost_stall_M", stall_M, 1);
    serve(0, 32'h0BADCAFE);
    chk("rpost_dm_ready", dm_ready, 1);
    chk("rpost_dm_rdata", dm_rdata, 32'h0BADCAFE);
    dm_req = 0;
    @(negedge clk);
    chk("rpost_dm_ready_pulse", dm_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
